mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) port and memory-access (MA) load/store port. It sits between the `cpu` core and the memory model.
- Grants one transaction at a time, with MA priority and an IF anti-starvation counter.
- Translates the 2-bit size-coded `mem_read_ma`/`mem_write_ma` requests into word-aligned accesses with byte enables.
- Returns one-cycle ready pulses that the core uses as stall releases.

---
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch
// port and the load/store port, MA first with an IF anti-starvation count.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic [1:0]  ma_read,
  input  logic [1:0]  ma_write,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_wdata,
  output logic [31:0] ma_rdata,
  output logic        ma_ready,
  output logic        ma_misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_MA,
    MISAL
  } state_e;

  state_e      state_q;
  logic [3:0]  starve_q;
  logic        killed_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] ma_rdata_q;
  logic        if_ready_q;
  logic        ma_ready_q;
  logic        ma_mis_q;

  logic        if_elig;
  logic        ma_elig;
  logic        grant_ma;
  logic        grant_if;
  logic        ma_we;
  logic [1:0]  ma_size;
  logic        ma_misal;
  logic [3:0]  ma_be;
  logic [31:0] ma_wrep;
  logic [3:0]  starve_d;
  logic        unused;

  assign unused = ^if_addr[1:0];

  // A port whose ready is high this cycle is still holding the
  // request it was just served for, so it must not be re-granted.
  always_comb begin
    ma_we    = ma_write != 2'b00;
    ma_size  = ma_we ? ma_write : ma_read;
    if_elig  = if_req && !if_kill && !if_ready_q;
    ma_elig  = (ma_size != 2'b00) && !ma_ready_q;
    grant_ma = ma_elig && !(if_elig && starve_q == SMAX);
    grant_if = if_elig && !grant_ma;
    starve_d = (&starve_q) ? starve_q : starve_q + 4'd1;
    ma_misal = 1'b0;
    ma_be    = 4'hF;
    ma_wrep  = ma_wdata;
    unique case (ma_size)
      2'b01: begin
        ma_be   = 4'b0001 << ma_addr[1:0];
        ma_wrep = {4{ma_wdata[7:0]}};
      end
      2'b10: begin
        ma_misal = ma_addr[0];
        ma_be    = 4'b0011 << {ma_addr[1], 1'b0};
        ma_wrep  = {2{ma_wdata[15:0]}};
      end
      2'b11: ma_misal = ma_addr[1:0] != 2'b00;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      killed_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      ma_rdata_q  <= 32'd0;
      if_ready_q  <= 1'b0;
      ma_ready_q  <= 1'b0;
      ma_mis_q    <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      ma_ready_q <= 1'b0;
      ma_mis_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_ma) begin
            if (if_elig) starve_q <= starve_d;
            if (ma_misal) begin
              state_q <= MISAL;
            end else begin
              state_q     <= BUSY_MA;
              mem_req_q   <= 1'b1;
              mem_we_q    <= ma_we;
              mem_addr_q  <= {ma_addr[31:2], 2'b00};
              mem_be_q    <= ma_be;
              mem_wdata_q <= ma_wrep;
            end
          end else if (grant_if) begin
            starve_q    <= 4'd0;
            state_q     <= BUSY_IF;
            killed_q    <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {if_addr[31:2], 2'b00};
            mem_be_q    <= 4'hF;
            mem_wdata_q <= 32'd0;
          end
        end
        BUSY_IF: begin
          if (if_kill) killed_q <= 1'b1;
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
            if (!(killed_q || if_kill)) begin
              if_rdata_q <= mem_rdata;
              if_ready_q <= 1'b1;
            end
          end
        end
        BUSY_MA: begin
          if (mem_ack) begin
            mem_req_q  <= 1'b0;
            state_q    <= IDLE;
            ma_ready_q <= 1'b1;
            if (!mem_we_q) ma_rdata_q <= mem_rdata;
          end
        end
        MISAL: begin
          state_q    <= IDLE;
          ma_ready_q <= 1'b1;
          ma_mis_q   <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rdata      = if_rdata_q;
  assign if_ready      = if_ready_q;
  assign ma_rdata      = ma_rdata_q;
  assign ma_ready      = ma_ready_q;
  assign ma_misaligned = ma_mis_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner sequences and random ops
// checked against a byte-array memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic [1:0]  ma_read;
  logic [1:0]  ma_write;
  logic [31:0] ma_addr;
  logic [31:0] ma_wdata;
  logic [31:0] ma_rdata;
  logic        ma_ready;
  logic        ma_misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .ma_read(ma_read), .ma_write(ma_write), .ma_addr(ma_addr),
    .ma_wdata(ma_wdata), .ma_rdata(ma_rdata), .ma_ready(ma_ready),
    .ma_misaligned(ma_misaligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    case (i)
      0: return 32'h0BADF00D;
      1: return 32'h11111111;
      2: return 32'h000000CC;
      3: return 32'h33333333;
      4: return 32'h00A00093;
      8: return 32'h88888888;
      default: return 32'(i) * 32'h01010101;
    endcase
  endfunction

  // Memory device: acks after mdelay wait cycles, combinational at 0.
  logic [31:0] mem [0:63];
  logic        load_mem;
  logic        force_ack;
  int          mdelay = 0;
  int          wcnt = 0;

  assign mem_rdata = mem[mem_addr[7:2]];
  assign mem_ack   = force_ack || (mem_req && wcnt >= mdelay);

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_req && mem_ack && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  logic [7:0]  ref_mem [0:255];
  logic [31:0] exp_ma;
  int n_cmp = 0;
  int n_bad = 0;

  int          o_lat, o_who;
  logic        o_req, o_we, o_mis, o_clean;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wd, o_rd;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref_word(logic [31:0] a);
    int b;
    b = int'({a[7:2], 2'b00});
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic ref_store(logic [31:0] a, int n, logic [31:0] wd);
    for (int k = 0; k < n; k++)
      ref_mem[(int'(a[7:0]) + k) % 256] = wd[8*k +: 8];
  endtask

  // kind: 0 fetch, 1 load, 2 store
  task automatic run_op(int kind, logic [1:0] sz, logic [31:0] a,
                        logic [31:0] wd, int d);
    o_lat = -1; o_who = -1; o_req = 0; o_we = 0; o_mis = 0;
    o_be = 0; o_addr = 0; o_wd = 0; o_rd = 0;
    @(negedge clk);
    mdelay = d;
    if (kind == 0) begin
      if_req = 1; if_addr = a;
    end else if (kind == 1) begin
      ma_read = sz; ma_addr = a;
    end else begin
      ma_write = sz; ma_addr = a; ma_wdata = wd;
    end
    for (int c = 1; c <= 30 && o_lat < 0; c++) begin
      @(negedge clk);
      if (mem_req) o_req = 1;
      if (mem_req && mem_ack) begin
        o_be = mem_be; o_addr = mem_addr; o_we = mem_we; o_wd = mem_wdata;
      end
      if (if_ready || ma_ready) begin
        o_lat = c;
        o_who = if_ready ? 0 : 1;
        o_rd  = (kind == 0) ? if_rdata : ma_rdata;
        o_mis = ma_misaligned;
        if_req = 0; ma_read = 0; ma_write = 0;
      end
    end
    if_req = 0; ma_read = 0; ma_write = 0;
    @(negedge clk);
    o_clean = !if_ready && !ma_ready;
  endtask

  task automatic check_op(string tag, int kind, int lat, logic mis,
                          logic [3:0] be, logic [31:0] ma,
                          logic [31:0] wd, logic [31:0] rd);
    chk({tag, ".lat"}, o_lat, lat);
    chk({tag, ".port"}, o_who, (kind == 0) ? 0 : 1);
    chk({tag, ".mis"}, o_mis, mis);
    chk({tag, ".memreq"}, o_req, !mis);
    chk({tag, ".rdata"}, o_rd, rd);
    chk({tag, ".pulse"}, o_clean, 1);
    if (!mis) begin
      chk({tag, ".be"}, o_be, be);
      chk({tag, ".addr"}, o_addr, ma);
      chk({tag, ".we"}, o_we, kind == 2);
      if (kind == 2) chk({tag, ".wdata"}, o_wd, wd);
    end
  endtask

  typedef struct {
    int          kind;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    int          d;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] ma;
    logic [31:0] wexp;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [14];

  logic [31:0] glog [$];
  logic [31:0] w, a_r, wd_r, e_rd, e_wd, rd_if, rd_ma;
  logic [3:0]  e_be;
  logic [1:0]  sz_r;
  logic        e_mis, seen, bad, got_if, pr;
  int          kind_r, d_r, n_r, first_if;

  initial begin
    vt[0]  = '{0, 2'd3, 32'h10, 32'h0, 0, 1'b0, 4'hF, 32'h10, 32'h0, 32'h00A00093};
    vt[1]  = '{1, 2'd3, 32'h08, 32'h0, 0, 1'b0, 4'hF, 32'h08, 32'h0, 32'h000000CC};
    vt[2]  = '{2, 2'd1, 32'h0E, 32'hAB, 0, 1'b0, 4'h4, 32'h0C, 32'hABABABAB, 32'h000000CC};
    vt[3]  = '{2, 2'd2, 32'h06, 32'h1234, 1, 1'b0, 4'hC, 32'h04, 32'h12341234, 32'h000000CC};
    vt[4]  = '{1, 2'd3, 32'h05, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h000000CC};
    vt[5]  = '{1, 2'd3, 32'h04, 32'h0, 0, 1'b0, 4'hF, 32'h04, 32'h0, 32'h12341111};
    vt[6]  = '{1, 2'd1, 32'h0E, 32'h0, 2, 1'b0, 4'h4, 32'h0C, 32'h0, 32'h33AB3333};
    vt[7]  = '{1, 2'd2, 32'h03, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h33AB3333};
    vt[8]  = '{1, 2'd2, 32'h02, 32'h0, 0, 1'b0, 4'hC, 32'h00, 32'h0, 32'h0BADF00D};
    vt[9]  = '{2, 2'd3, 32'h18, 32'hDEADBEEF, 1, 1'b0, 4'hF, 32'h18, 32'hDEADBEEF, 32'h0BADF00D};
    vt[10] = '{2, 2'd3, 32'h1A, 32'h55, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0BADF00D};
    vt[11] = '{1, 2'd3, 32'h18, 32'h0, 0, 1'b0, 4'hF, 32'h18, 32'h0, 32'hDEADBEEF};
    vt[12] = '{0, 2'd3, 32'h22, 32'h0, 1, 1'b0, 4'hF, 32'h20, 32'h0, 32'h88888888};
    vt[13] = '{2, 2'd1, 32'h03, 32'h5A, 0, 1'b0, 4'h8, 32'h00, 32'h5A5A5A5A, 32'hDEADBEEF};

    for (int i = 0; i < 64; i++) begin
      w = init_word(i);
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end

    reset = 0; load_mem = 1; force_ack = 0;
    if_req = 0; if_addr = 0; if_kill = 0;
    ma_read = 0; ma_write = 0; ma_addr = 0; ma_wdata = 0;
    repeat (3) @(negedge clk);
    chk("reset.ctrl", {if_ready, ma_ready, ma_misaligned, mem_req, mem_we, mem_be}, 0);
    chk("reset.rdata", {if_rdata, ma_rdata}, 0);
    chk("reset.bus", {mem_addr, mem_wdata}, 0);
    reset = 1; load_mem = 0;

    foreach (vt[i]) begin
      run_op(vt[i].kind, vt[i].sz, vt[i].a, vt[i].wd, vt[i].d);
      check_op($sformatf("vec%0d", i), vt[i].kind,
               vt[i].mis ? 2 : 2 + vt[i].d, vt[i].mis, vt[i].be,
               vt[i].ma, vt[i].wexp, vt[i].rd);
      if (vt[i].kind == 2 && !vt[i].mis)
        ref_store(vt[i].a, (vt[i].sz == 2'd3) ? 4 : int'(vt[i].sz), vt[i].wd);
    end

    // IF and MA together: MA first, then IF.
    glog.delete(); pr = 0; got_if = 0; rd_if = 0; rd_ma = 0;
    @(negedge clk);
    mdelay = 0; ma_read = 2'b11; ma_addr = 32'h08; if_req = 1; if_addr = 32'h10;
    for (int c = 0; c < 30 && !got_if; c++) begin
      @(negedge clk);
      if (mem_req && !pr) glog.push_back(mem_addr);
      pr = mem_req;
      if (ma_ready) begin ma_read = 0; rd_ma = ma_rdata; end
      if (if_ready) begin if_req = 0; rd_if = if_rdata; got_if = 1; end
    end
    if_req = 0; ma_read = 0;
    chk("both.first", glog.size() > 0 ? glog[0] : 32'hFFFFFFFF, 32'h08);
    chk("both.second", glog.size() > 1 ? glog[1] : 32'hFFFFFFFF, 32'h10);
    chk("both.ma_rdata", rd_ma, 32'hCC);
    chk("both.if_rdata", rd_if, 32'h00A00093);
    repeat (2) @(negedge clk);

    // Held MA load with IF pending; IF is masked during MA ready cycles
    // so that only the starve counter can let it through.
    glog.delete(); pr = 0; got_if = 0;
    @(negedge clk);
    mdelay = 0; ma_read = 2'b11; ma_addr = 32'h08; if_req = 1; if_addr = 32'h10;
    for (int c = 0; c < 80 && !got_if; c++) begin
      @(negedge clk);
      if (mem_req && !pr) glog.push_back(mem_addr);
      pr = mem_req;
      if_kill = ma_ready;
      if (if_ready) begin got_if = 1; if_req = 0; ma_read = 0; end
    end
    if_kill = 0; if_req = 0; ma_read = 0;
    first_if = -1;
    foreach (glog[i]) if (glog[i] == 32'h10 && first_if < 0) first_if = i;
    chk("starve.ma_grants", first_if, 4);
    chk("starve.if_served", got_if, 1);
    repeat (3) @(negedge clk);

    // Kill during a slow fetch.
    seen = 0; bad = 0; pr = 0;
    @(negedge clk);
    mdelay = 3; if_req = 1; if_addr = 32'h20;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_req && !pr) begin if_kill = 1; if_req = 0; pr = 1; end
      else if_kill = 0;
      if (mem_req && mem_ack) seen = 1;
      if (if_ready) bad = 1;
    end
    if_kill = 0;
    chk("kill.ack_seen", seen, 1);
    chk("kill.no_ready", bad, 0);
    chk("kill.if_rdata", if_rdata, 32'h00A00093);
    chk("kill.req_idle", mem_req, 0);
    run_op(0, 2'd3, 32'h24, 32'h0, 0);
    check_op("kill.next", 0, 2, 1'b0, 4'hF, 32'h24, 32'h0, 32'h09090909);

    // Reset while a slow load is outstanding, then a stray ack.
    seen = 0; bad = 0;
    @(negedge clk);
    mdelay = 5; ma_read = 2'b11; ma_addr = 32'h0C;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk);
      seen = mem_req;
    end
    chk("rst.req_before", seen, 1);
    reset = 0; ma_read = 0;
    #1;
    chk("rst.ctrl", {if_ready, ma_ready, ma_misaligned, mem_req, mem_we, mem_be}, 0);
    chk("rst.rdata", {if_rdata, ma_rdata}, 0);
    chk("rst.bus", {mem_addr, mem_wdata}, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    force_ack = 1;
    @(negedge clk);
    force_ack = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (if_ready || ma_ready || mem_req) bad = 1;
    end
    chk("rst.late_ack", bad, 0);
    run_op(1, 2'd3, 32'h08, 32'h0, 0);
    check_op("rst.next", 1, 2, 1'b0, 4'hF, 32'h08, 32'h0, 32'hCC);
    exp_ma = 32'hCC;

    for (int t = 0; t < 200; t++) begin
      kind_r = $urandom_range(0, 2);
      sz_r   = 2'($urandom_range(1, 3));
      a_r    = $urandom_range(0, 255);
      wd_r   = $urandom;
      d_r    = $urandom_range(0, 3);
      n_r    = (kind_r == 0 || sz_r == 2'd3) ? 4 : int'(sz_r);
      e_mis  = (kind_r != 0) && ((int'(a_r) % n_r) != 0);
      e_be   = 4'h0;
      if (kind_r == 0) e_be = 4'hF;
      else if (!e_mis)
        for (int k = 0; k < n_r; k++) e_be[int'(a_r[1:0]) + k] = 1'b1;
      for (int l = 0; l < 4; l++) e_wd[8*l +: 8] = wd_r[8*(l % n_r) +: 8];
      if (kind_r == 0) e_rd = ref_word(a_r);
      else if (kind_r == 1 && !e_mis) begin
        e_rd = ref_word(a_r);
        exp_ma = e_rd;
      end else e_rd = exp_ma;
      run_op(kind_r, sz_r, a_r, wd_r, d_r);
      check_op($sformatf("rnd%0d", t), kind_r, e_mis ? 2 : 2 + d_r, e_mis,
               e_be, {a_r[31:2], 2'b00}, e_wd, e_rd);
      if (kind_r == 2 && !e_mis) ref_store(a_r, n_r, wd_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
